tictactoe_ctrl: RTL and testbench
=================================

# tictactoe_ctrl

Sequential game controller for the tic-tac-toe datapath: owns the two 9-bit occupancy boards, accepts one move per turn over a valid/ready handshake, alternates players, and sequences a combinational board evaluator after every accepted move. It declares the result (X win, O win, draw) and enforces an optional per-turn timeout. It sits between the move source (keypad/UI logic) and the display/score logic.

## Interface
- FIRST_PLAYER, 0, player moving first after `start` (0 = X, 1 = O)
- TIMEOUT_CYCLES, 0, cycles allowed per turn before forfeit of the turn; 0 disables the timer
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- start  in  1  pulse: clear board and begin a new game
- mv_valid  in  1  move request present
- mv_pos  in  4  cell index 0..8, row-major, bit i of the boards
- mv_ready  out  1  controller accepts a move this cycle
- mv_accept  out  1  one-cycle pulse: move written
- mv_reject  out  1  one-cycle pulse: move refused
- rej_code  out  2  01 cell occupied, 10 mv_pos > 8; 00 otherwise
- turn  out  1  player to move (0 = X, 1 = O)
- x_board  out  9  X occupancy
- o_board  out  9  O occupancy
- moves  out  4  accepted moves this game, 0..9
- game_over  out  1  high in OVER
- result  out  2  00 none, 01 X won, 10 O won, 11 draw
- timeout  out  1  one-cycle pulse: turn forfeited
- fault  out  1  sticky: evaluator reported overlapping X/O cells

## Operation
- States: IDLE, PLAY, EVAL, OVER. Reset → IDLE. All outputs are 0 in reset, except `turn`, which resets to FIRST_PLAYER.
- IDLE and OVER: `mv_ready`=0. Boards and result hold.
- `start` in any state: clear boards, set `moves`=0, `result`=00, `fault`=0, `turn`=FIRST_PLAYER, clear the timer, next state PLAY.
  - `start` has priority over a same-cycle move and over timeout. Neither takes effect and neither pulses.
- PLAY: `mv_ready`=1. A transfer occurs when mv_valid & mv_ready at a clock edge.
  - Legal move (mv_pos ≤ 8 and the cell is empty in both boards): set the bit in the current player's board, increment `moves`, pulse `mv_accept`, go to EVAL.
  - Illegal move: pulse `mv_reject` with `rej_code`, stay in PLAY. The turn and the timer are unchanged.
  - If mv_pos > 8 and the cell is also "occupied", code 10 wins.
- EVAL: `mv_ready`=0. Evaluate the registered boards with the following priority:
  - overlap → set `fault`, `result`=00, go to OVER;
  - X three-in-line → 01, OVER;
  - O three-in-line → 10, OVER;
  - full board → 11, OVER;
  - otherwise toggle `turn`, clear the timer, go to PLAY.
- A winning ninth move reports the win, not a draw.
- Timer, active only in PLAY with TIMEOUT_CYCLES > 0:
  - counts cycles since entering PLAY;
  - at count TIMEOUT_CYCLES−1 with no legal transfer that cycle, pulse `timeout`, toggle `turn`, clear the count, and stay in PLAY.
  - A legal transfer on the expiry cycle wins over timeout.
- Timer width is $clog2(TIMEOUT_CYCLES+1), minimum 1. `moves` saturates at 9 and cannot exceed it.

## Timing
- Board, `moves`, pulses and state all update at the same edge as the transfer.
- `mv_accept`, `mv_reject` and `rej_code` are registered. They are high for exactly the cycle after the transfer edge. `rej_code` is 00 whenever `mv_reject`=0.
- Move-to-ready latency: `mv_ready` drops for exactly one cycle (EVAL) after an accept, then rises again if the game continues.
- Move-to-result latency: `result` and `game_over` are valid 2 cycles after the transfer edge.
- After a reject, `mv_ready` stays high. A requester holding the same illegal request is rejected every cycle.
- `rst` mid-game aborts immediately to the reset values. A same-cycle `start` is ignored.

## Structure
- Package tictactoe_pkg:
  - state enum (IDLE, PLAY, EVAL, OVER);
  - result constants RES_NONE, RES_X, RES_O, RES_DRAW;
  - reject codes REJ_NONE, REJ_OCC, REJ_RANGE;
  - player constants PL_X, PL_O.
- One sub-module, tictactoe_eval: purely combinational, taking x/o boards and producing overlap, full, x-line and o-line. Instantiated once on the registered boards.

## Test plan
- Win for X. Sequence: start, then X moves 0, O 3, X 1, O 4, X 2. Expected: 5 accepts, `result`=01 and `game_over`=1 two cycles after the last transfer, x_board=0x007, o_board=0x018, `moves`=5, `mv_ready`=0.
- Draw. Sequence: X 0, O 1, X 2, O 4, X 3, O 5, X 7, O 6, X 8. Expected: `result`=11, `moves`=9, x_board|o_board=0x1FF.
- Occupied cell, then out of range. After X takes 4, O tries cell 4, then cell 12. Expected: reject pulses with codes 01 then 10, `turn`=1 throughout, boards unchanged.
- Timeout with TIMEOUT_CYCLES=5. Hold `mv_valid` low for 5 cycles. Expected: one `timeout` pulse, `turn` X→O, `moves` unchanged. A legal move on the expiry cycle is accepted with no `timeout` pulse.
- `start` with a same-cycle `mv_valid` mid-game. Expected: boards=0, `moves`=0, `turn`=FIRST_PLAYER, no accept or reject pulse.
- `rst` mid-game. Expected: IDLE, all outputs at their reset values, `mv_ready`=0 until `start`.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe controller and its evaluator.
// Latency: n/a (declarations and one combinational helper only).
// Backpressure: n/a.
package tictactoe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        EVAL = 2'd2,
        OVER = 2'd3
    } state_e;

    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_X     = 2'b01;
    localparam logic [1:0] RES_O     = 2'b10;
    localparam logic [1:0] RES_DRAW  = 2'b11;

    localparam logic [1:0] REJ_NONE  = 2'b00;
    localparam logic [1:0] REJ_OCC   = 2'b01;
    localparam logic [1:0] REJ_RANGE = 2'b10;

    localparam logic PL_X = 1'b0;
    localparam logic PL_O = 1'b1;

    // The eight winning lines on a row-major 3x3 board (bit i = cell i).
    localparam logic [8:0] LINE_MASKS [8] = '{
        9'b000_000_111, 9'b000_111_000, 9'b111_000_000,
        9'b001_001_001, 9'b010_010_010, 9'b100_100_100,
        9'b100_010_001, 9'b001_010_100
    };

    function automatic logic has_line(input logic [8:0] board);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((board & LINE_MASKS[i]) == LINE_MASKS[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/tictactoe_eval.sv
// Board evaluator: flags overlap, full board and a three-in-line for X and O.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the boards continuously.
// Ports: x_board_i/o_board_i occupancy in; overlap_o, full_o, x_line_o, o_line_o out.
module tictactoe_eval
    import tictactoe_pkg::*;
(
    input  logic [8:0] x_board_i,
    input  logic [8:0] o_board_i,
    output logic       overlap_o,
    output logic       full_o,
    output logic       x_line_o,
    output logic       o_line_o
);

    assign overlap_o = |(x_board_i & o_board_i);
    assign full_o    = &(x_board_i | o_board_i);
    assign x_line_o  = has_line(x_board_i);
    assign o_line_o  = has_line(o_board_i);

endmodule

// File: rtl/tictactoe_ctrl.sv
// Game controller: owns both boards, accepts moves, alternates players, declares result.
// Latency: accept/reject pulse 1 cycle after transfer; result/game_over after 1 EVAL cycle.
// Backpressure: mv_ready only in PLAY; low for one EVAL cycle after each accepted move.
// Ports: clk, rst (sync, active-high), start, mv_valid/mv_pos/mv_ready move handshake;
//        mv_accept/mv_reject/rej_code/timeout pulses; turn, x_board, o_board, moves,
//        game_over, result, fault status.
module tictactoe_ctrl
    import tictactoe_pkg::*;
#(
    parameter int FIRST_PLAYER   = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mv_valid,
    input  logic [3:0] mv_pos,
    output logic       mv_ready,
    output logic       mv_accept,
    output logic       mv_reject,
    output logic [1:0] rej_code,
    output logic       turn,
    output logic [8:0] x_board,
    output logic [8:0] o_board,
    output logic [3:0] moves,
    output logic       game_over,
    output logic [1:0] result,
    output logic       timeout,
    output logic       fault
);

    localparam int         TW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic       FP       = (FIRST_PLAYER != 0);
    localparam logic       TIMER_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0] TMAX  = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    state_e        state_q, state_d;
    logic [8:0]    x_q, x_d, o_q, o_d;
    logic [3:0]    moves_q, moves_d;
    logic          turn_q, turn_d;
    logic [1:0]    result_q, result_d;
    logic          fault_q, fault_d;
    logic          acc_q, acc_d;
    logic          rej_q, rej_d;
    logic [1:0]    rej_code_q, rej_code_d;
    logic          tmo_q, tmo_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          ev_overlap, ev_full, ev_xline, ev_oline;
    logic [15:0]   occ_ext;
    logic          in_range, cell_occ, xfer, legal, expire;
    logic [8:0]    cell_bit;

    tictactoe_eval u_eval (
        .x_board_i (x_q),
        .o_board_i (o_q),
        .overlap_o (ev_overlap),
        .full_o    (ev_full),
        .x_line_o  (ev_xline),
        .o_line_o  (ev_oline)
    );

    // Zero-extended occupancy so an out-of-range index reads as empty;
    // the range check then decides the reject code.
    assign occ_ext  = {7'd0, x_q | o_q};
    assign in_range = (mv_pos <= 4'd8);
    assign cell_occ = occ_ext[mv_pos];
    assign xfer     = mv_valid && (state_q == PLAY);
    assign legal    = xfer && in_range && !cell_occ;
    assign expire   = TIMER_EN && (state_q == PLAY) && (timer_q == TMAX);
    assign cell_bit = in_range ? (9'd1 << mv_pos) : 9'd0;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        o_d        = o_q;
        moves_d    = moves_q;
        turn_d     = turn_q;
        result_d   = result_q;
        fault_d    = fault_q;
        timer_d    = timer_q;
        acc_d      = 1'b0;
        rej_d      = 1'b0;
        rej_code_d = REJ_NONE;
        tmo_d      = 1'b0;

        if (start) begin
            // New game overrides any same-cycle move or expiry.
            state_d  = PLAY;
            x_d      = '0;
            o_d      = '0;
            moves_d  = '0;
            result_d = RES_NONE;
            fault_d  = 1'b0;
            turn_d   = FP;
            timer_d  = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (legal) begin
                        if (turn_q == PL_X) x_d = x_q | cell_bit;
                        else                o_d = o_q | cell_bit;
                        moves_d = (moves_q >= 4'd9) ? 4'd9 : moves_q + 4'd1;
                        acc_d   = 1'b1;
                        state_d = EVAL;
                    end else begin
                        if (xfer) begin
                            rej_d      = 1'b1;
                            rej_code_d = in_range ? REJ_OCC : REJ_RANGE;
                        end
                        // A refused move does not restart the turn clock.
                        if (expire) begin
                            tmo_d   = 1'b1;
                            turn_d  = ~turn_q;
                            timer_d = '0;
                        end else if (TIMER_EN) begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
                EVAL: begin
                    if (ev_overlap) begin
                        fault_d  = 1'b1;
                        result_d = RES_NONE;
                        state_d  = OVER;
                    end else if (ev_xline) begin
                        result_d = RES_X;
                        state_d  = OVER;
                    end else if (ev_oline) begin
                        result_d = RES_O;
                        state_d  = OVER;
                    end else if (ev_full) begin
                        result_d = RES_DRAW;
                        state_d  = OVER;
                    end else begin
                        turn_d  = ~turn_q;
                        timer_d = '0;
                        state_d = PLAY;
                    end
                end
                default: ;  // IDLE and OVER hold everything
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            o_q        <= '0;
            moves_q    <= '0;
            turn_q     <= FP;
            result_q   <= RES_NONE;
            fault_q    <= 1'b0;
            timer_q    <= '0;
            acc_q      <= 1'b0;
            rej_q      <= 1'b0;
            rej_code_q <= REJ_NONE;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            o_q        <= o_d;
            moves_q    <= moves_d;
            turn_q     <= turn_d;
            result_q   <= result_d;
            fault_q    <= fault_d;
            timer_q    <= timer_d;
            acc_q      <= acc_d;
            rej_q      <= rej_d;
            rej_code_q <= rej_code_d;
            tmo_q      <= tmo_d;
        end
    end

    assign mv_ready  = (state_q == PLAY);
    assign game_over = (state_q == OVER);
    assign mv_accept = acc_q;
    assign mv_reject = rej_q;
    assign rej_code  = rej_code_q;
    assign timeout   = tmo_q;
    assign turn      = turn_q;
    assign x_board   = x_q;
    assign o_board   = o_q;
    assign moves     = moves_q;
    assign result    = result_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_tictactoe_ctrl.sv
// Directed bench for tictactoe_ctrl with a pulse scoreboard and a reference board model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tictactoe_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, mv_valid;
    logic [3:0] mv_pos;
    logic       mv_ready, mv_accept, mv_reject, turn, game_over, timeout, fault;
    logic [1:0] rej_code, result;
    logic [8:0] x_board, o_board;
    logic [3:0] moves;

    tictactoe_ctrl #(.FIRST_PLAYER(0), .TIMEOUT_CYCLES(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mv_valid  (mv_valid),
        .mv_pos    (mv_pos),
        .mv_ready  (mv_ready),
        .mv_accept (mv_accept),
        .mv_reject (mv_reject),
        .rej_code  (rej_code),
        .turn      (turn),
        .x_board   (x_board),
        .o_board   (o_board),
        .moves     (moves),
        .game_over (game_over),
        .result    (result),
        .timeout   (timeout),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       acc;
        logic       rej;
        logic [1:0] code;
        logic       tmo;
    } exp_t;

    exp_t sb[$];

    int         tests  = 0;
    int         failed = 0;
    logic [8:0] x_m, o_m;
    logic [3:0] moves_m;
    logic       turn_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic a, input logic r, input logic [1:0] c, input logic t);
        exp_t e;
        e.acc = a; e.rej = r; e.code = c; e.tmo = t;
        sb.push_back(e);
    endtask

    task automatic check_pulses(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            failed++;
            $error("FAIL %s: scoreboard empty, observed acc=%0b rej=%0b", tag, mv_accept, mv_reject);
        end else begin
            e = sb.pop_front();
            chk({tag, " accept"},  mv_accept, e.acc);
            chk({tag, " reject"},  mv_reject, e.rej);
            chk({tag, " rej_code"}, rej_code, e.code);
            chk({tag, " timeout"}, timeout,   e.tmo);
        end
    endtask

    task automatic chk_board(input string tag);
        chk({tag, " x_board"}, x_board, x_m);
        chk({tag, " o_board"}, o_board, o_m);
        chk({tag, " moves"},   moves,   moves_m);
        chk({tag, " turn"},    turn,    turn_m);
        chk({tag, " fault"},   fault,   1'b0);
    endtask

    // Drive one move in PLAY; exp_res is the result the author expects after it (00 = game continues).
    task automatic move(input logic [3:0] pos, input logic [1:0] exp_res);
        logic [15:0] occ;
        logic        legal;
        occ   = {7'd0, x_m | o_m};
        legal = (pos <= 4'd8) && !occ[pos];
        push_exp(legal, !legal, legal ? 2'b00 : ((pos > 4'd8) ? 2'b10 : 2'b01), 1'b0);
        mv_valid = 1'b1;
        mv_pos   = pos;
        step();
        mv_valid = 1'b0;
        check_pulses($sformatf("move%0d", pos));
        if (legal) begin
            if (turn_m) o_m[pos] = 1'b1;
            else        x_m[pos] = 1'b1;
            moves_m++;
            chk_board("after accept");
            chk("eval ready", mv_ready, 1'b0);
            chk("eval over",  game_over, 1'b0);
            push_exp(1'b0, 1'b0, 2'b00, 1'b0);
            step();
            check_pulses("eval cycle");
            if (exp_res != 2'b00) begin
                chk("over flag",  game_over, 1'b1);
                chk("result",     result,    exp_res);
                chk("over ready", mv_ready,  1'b0);
            end else begin
                turn_m = ~turn_m;
                chk("continue ready",  mv_ready, 1'b1);
                chk("continue result", result,   2'b00);
                chk("next turn",       turn,     turn_m);
            end
        end else begin
            chk_board("after reject");
            chk("reject ready", mv_ready, 1'b1);
        end
    endtask

    task automatic idle_step(input logic exp_tmo);
        push_exp(1'b0, 1'b0, 2'b00, exp_tmo);
        step();
        check_pulses("idle");
        if (exp_tmo) turn_m = ~turn_m;
        chk_board("idle");
    endtask

    task automatic do_start(input logic with_mv);
        start    = 1'b1;
        mv_valid = with_mv;
        mv_pos   = 4'd0;
        push_exp(1'b0, 1'b0, 2'b00, 1'b0);
        step();
        start    = 1'b0;
        mv_valid = 1'b0;
        check_pulses("start");
        x_m = '0; o_m = '0; moves_m = '0; turn_m = 1'b0;
        chk_board("start");
        chk("start ready",  mv_ready,  1'b1);
        chk("start over",   game_over, 1'b0);
        chk("start result", result,    2'b00);
    endtask

    task automatic chk_reset(input string tag);
        x_m = '0; o_m = '0; moves_m = '0; turn_m = 1'b0;
        chk_board(tag);
        chk({tag, " ready"},  mv_ready,  1'b0);
        chk({tag, " over"},   game_over, 1'b0);
        chk({tag, " result"}, result,    2'b00);
        chk({tag, " accept"}, mv_accept, 1'b0);
        chk({tag, " reject"}, mv_reject, 1'b0);
        chk({tag, " code"},   rej_code,  2'b00);
        chk({tag, " tmo"},    timeout,   1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mv_valid = 1'b0; mv_pos = 4'd0;
        x_m = '0; o_m = '0; moves_m = '0; turn_m = 1'b0;
        step();
        step();
        chk_reset("reset");
        rst = 1'b0;
        step();
        chk("idle ready", mv_ready, 1'b0);

        // X wins on the top row.
        do_start(1'b0);
        move(4'd0, 2'b00);
        move(4'd3, 2'b00);
        move(4'd1, 2'b00);
        move(4'd4, 2'b00);
        move(4'd2, 2'b01);
        chk("win x_board", x_board, 9'h007);
        chk("win o_board", o_board, 9'h018);
        chk("win moves",   moves,   4'd5);
        step();
        chk("over holds ready", mv_ready, 1'b0);
        chk("over holds result", result, 2'b01);

        // Occupied and out-of-range rejects, then start with a same-cycle move.
        do_start(1'b0);
        move(4'd4, 2'b00);
        move(4'd4, 2'b00);
        move(4'd12, 2'b00);
        chk("reject turn O", turn, 1'b1);
        move(4'd0, 2'b00);
        do_start(1'b1);

        // Draw over nine moves.
        move(4'd0, 2'b00);
        move(4'd1, 2'b00);
        move(4'd2, 2'b00);
        move(4'd4, 2'b00);
        move(4'd3, 2'b00);
        move(4'd5, 2'b00);
        move(4'd7, 2'b00);
        move(4'd6, 2'b00);
        move(4'd8, 2'b11);
        chk("draw moves", moves, 4'd9);
        chk("draw full",  x_board | o_board, 9'h1FF);
        chk("draw x_board", x_board, 9'h18D);

        // Turn timeout, then a legal move landing on the expiry cycle.
        do_start(1'b0);
        for (int i = 0; i < 4; i++) idle_step(1'b0);
        idle_step(1'b1);
        chk("timeout turn O", turn, 1'b1);
        for (int i = 0; i < 4; i++) idle_step(1'b0);
        move(4'd5, 2'b00);
        chk("expiry move o_board", o_board, 9'h020);

        // Reset mid-game beats a same-cycle start.
        move(4'd2, 2'b00);
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        chk_reset("mid reset");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post reset ready", mv_ready, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
